cochlea_readout_scanner: RTL and testbench

//  Frame-based readout controller for the chained filter-cell array. On each phi1b_dig

---
 rtl/cochlea_readout_scanner.sv | 159 +++++++++++++++
 tb/tb_cochlea_readout_scanner.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cochlea_readout_scanner.sv
// Frame-based readout scanner: snapshots all cell I/Q readouts on a phi1b_dig rising edge,
// scans enabled channels one per cycle into a first-word-fall-through FIFO, and keeps sticky error flags.
module cochlea_readout_scanner #(
  parameter int N_CH       = 16,
  parameter int CH_W       = $clog2(N_CH),
  parameter int FIFO_DEPTH = 8,
  parameter int DW         = CH_W + 5
) (
  input  logic              clk_master,
  input  logic              rstb,
  input  logic              en,
  input  logic              phi1b_dig,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [2*N_CH-1:0] read_out_I_bus,
  input  logic [2*N_CH-1:0] read_out_Q_bus,
  input  logic              clr_flags,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow,
  output logic              missed_frame,
  output logic [7:0]        drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e            state_q;
  logic [CH_W-1:0]   ch_idx_q;
  logic              frame_par_q;
  logic              phi_d_q;
  logic              frame_done_q;
  logic [2*N_CH-1:0] snap_i_q;
  logic [2*N_CH-1:0] snap_q_q;

  logic [DW-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              overflow_q;
  logic              missed_q;
  logic [7:0]        drop_cnt_q;

  logic              start;
  logic              push;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              miss;
  logic [CH_W:0]     bit_base;
  logic [DW-1:0]     push_word;

  assign start     = en & phi1b_dig & ~phi_d_q;
  assign miss      = start & (state_q == SCAN);
  // Dropping en mid-scan aborts immediately, so the aborting slot pushes nothing.
  assign push      = (state_q == SCAN) & en & ch_mask[ch_idx_q];
  assign bit_base  = {ch_idx_q, 1'b0};
  assign push_word = {frame_par_q, ch_idx_q, snap_i_q[bit_base +: 2], snap_q_q[bit_base +: 2]};

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & ((count_q != FULL_CNT) | pop);
  assign drop      = push & ~push_ok;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      ch_idx_q     <= '0;
      frame_par_q  <= 1'b0;
      phi_d_q      <= 1'b0;
      frame_done_q <= 1'b0;
      snap_i_q     <= '0;
      snap_q_q     <= '0;
    end else begin
      phi_d_q      <= phi1b_dig;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_i_q    <= read_out_I_bus;
            snap_q_q    <= read_out_Q_bus;
            ch_idx_q    <= '0;
            frame_par_q <= ~frame_par_q;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (ch_idx_q == LAST_CH) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end else begin
            ch_idx_q <= ch_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; out_data is gated by out_valid so stale entries never leak out.
  always_ff @(posedge clk_master) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new event in the same cycle as clr_flags wins over the clear.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      overflow_q <= 1'b0;
      missed_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (drop)           overflow_q <= 1'b1;
      else if (clr_flags) overflow_q <= 1'b0;

      if (miss)           missed_q <= 1'b1;
      else if (clr_flags) missed_q <= 1'b0;

      if (drop && clr_flags)         drop_cnt_q <= 8'd1;
      else if (clr_flags)            drop_cnt_q <= '0;
      else if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign frame_done   = frame_done_q;
  assign busy         = (state_q == SCAN);
  assign overflow     = overflow_q;
  assign missed_frame = missed_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_cochlea_readout_scanner.sv
// Self-checking bench for cochlea_readout_scanner: directed frame sequences, a table of
// mask/ready scenarios, and randomized traffic compared cycle by cycle with a queue-based model.
module tb_cochlea_readout_scanner;

  localparam int N_CH       = 16;
  localparam int CH_W       = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int DW         = CH_W + 5;

  logic              clk_master = 1'b0;
  logic              rstb;
  logic              en;
  logic              phi1b_dig;
  logic [N_CH-1:0]   ch_mask;
  logic [2*N_CH-1:0] read_out_I_bus;
  logic [2*N_CH-1:0] read_out_Q_bus;
  logic              clr_flags;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_done;
  logic              busy;
  logic              overflow;
  logic              missed_frame;
  logic [7:0]        drop_cnt;

  cochlea_readout_scanner #(
    .N_CH(N_CH), .CH_W(CH_W), .FIFO_DEPTH(FIFO_DEPTH), .DW(DW)
  ) dut (
    .clk_master    (clk_master),
    .rstb          (rstb),
    .en            (en),
    .phi1b_dig     (phi1b_dig),
    .ch_mask       (ch_mask),
    .read_out_I_bus(read_out_I_bus),
    .read_out_Q_bus(read_out_Q_bus),
    .clr_flags     (clr_flags),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .frame_done    (frame_done),
    .busy          (busy),
    .overflow      (overflow),
    .missed_frame  (missed_frame),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk_master = ~clk_master;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: slot = -1 when idle, otherwise the channel being scanned.
  int m_slot;
  bit m_phi_prev;
  int m_par;
  int m_snap_i [N_CH];
  int m_snap_q [N_CH];
  int m_fifo [$];
  bit m_done;
  bit m_ovf;
  bit m_miss;
  int m_drops;

  int rx_count;
  int rx_words [$];

  typedef struct {
    logic [N_CH-1:0] mask;
    bit              ready;
    int              exp_words;
    int              exp_drops;
    bit              exp_ovf;
  } row_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int cell_word(input int par, input int ch, input int i_val, input int q_val);
    return par * 256 + ch * 16 + i_val * 4 + q_val;
  endfunction

  task automatic model_reset();
    m_slot = -1; m_phi_prev = 1'b0; m_par = 0;
    m_done = 1'b0; m_ovf = 1'b0; m_miss = 1'b0; m_drops = 0;
    m_fifo.delete();
    for (int i = 0; i < N_CH; i++) begin
      m_snap_i[i] = 0;
      m_snap_q[i] = 0;
    end
  endtask

  task automatic model_step();
    bit start, pop, push, drop, miss;
    if (!rstb) begin
      model_reset();
      return;
    end
    start = en && phi1b_dig && !m_phi_prev;
    pop   = (m_fifo.size() > 0) && out_ready;
    push  = (m_slot >= 0) && en && ch_mask[m_slot];
    drop  = 1'b0;
    miss  = start && (m_slot >= 0);
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < FIFO_DEPTH)
        m_fifo.push_back(cell_word(m_par, m_slot, m_snap_i[m_slot], m_snap_q[m_slot]));
      else
        drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_flags) m_ovf = 1'b0;
    if (miss) m_miss = 1'b1;
    else if (clr_flags) m_miss = 1'b0;
    if (drop && clr_flags) m_drops = 1;
    else if (clr_flags) m_drops = 0;
    else if (drop && m_drops < 255) m_drops++;
    m_done = (m_slot == N_CH - 1) && en;
    if (m_slot >= 0) begin
      m_slot = (!en || m_slot == N_CH - 1) ? -1 : m_slot + 1;
    end else if (start) begin
      m_slot = 0;
      m_par  = 1 - m_par;
      for (int i = 0; i < N_CH; i++) begin
        m_snap_i[i] = int'(read_out_I_bus[2*i +: 2]);
        m_snap_q[i] = int'(read_out_Q_bus[2*i +: 2]);
      end
    end
    m_phi_prev = phi1b_dig;
  endtask

  task automatic compare_outputs();
    check("out_valid", out_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) check("out_data", out_data, m_fifo[0]);
    else check("out_data_idle", out_data, 0);
    check("frame_done", frame_done, m_done);
    check("busy", busy, m_slot >= 0);
    check("overflow", overflow, m_ovf);
    check("missed_frame", missed_frame, m_miss);
    check("drop_cnt", drop_cnt, m_drops);
  endtask

  // One clock cycle: inputs were set just after the previous rising edge.
  task automatic tick();
    @(negedge clk_master);
    compare_outputs();
    if (out_valid && out_ready) begin
      rx_count++;
      rx_words.push_back(int'(out_data));
    end
    model_step();
    @(posedge clk_master);
    #1;
  endtask

  task automatic drain_and_clear();
    phi1b_dig = 1'b0;
    out_ready = 1'b1;
    en        = 1'b1;
    repeat (20) tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_missed"}, missed_frame, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  row_t rows [7];

  initial begin
    rows[0] = '{16'hFFFF, 1'b1, 16, 0, 1'b0};
    rows[1] = '{16'h8001, 1'b1,  2, 0, 1'b0};
    rows[2] = '{16'hFFFF, 1'b0,  8, 8, 1'b1};
    rows[3] = '{16'h00FF, 1'b0,  8, 0, 1'b0};
    rows[4] = '{16'h0000, 1'b1,  0, 0, 1'b0};
    rows[5] = '{16'h0F0F, 1'b0,  8, 0, 1'b0};
    rows[6] = '{16'h7FFF, 1'b0,  8, 7, 1'b1};

    rstb = 1'b0; en = 1'b0; phi1b_dig = 1'b0; clr_flags = 1'b0; out_ready = 1'b0;
    ch_mask = '0; read_out_I_bus = '0; read_out_Q_bus = '0;
    rx_count = 0;
    model_reset();
    #3;
    check_all_zero("reset");
    @(posedge clk_master);
    #1;
    rstb = 1'b1;
    tick();

    // Single frame, full mask, cell i: I = i%4, Q = 3 - i%4.
    en = 1'b1; out_ready = 1'b1; ch_mask = '1;
    for (int i = 0; i < N_CH; i++) begin
      read_out_I_bus[2*i +: 2] = 2'(i % 4);
      read_out_Q_bus[2*i +: 2] = 2'(3 - i % 4);
    end
    rx_words.delete();
    phi1b_dig = 1'b1;
    tick();
    phi1b_dig = 1'b0;
    check("t1_valid_t1", out_valid, 0);
    tick();
    check("t1_valid_t2", out_valid, 1);
    check("t1_data_t2", out_data, cell_word(1, 0, 0, 3));
    repeat (14) tick();
    check("t1_done_t16", frame_done, 0);
    tick();
    check("t1_done_t17", frame_done, 1);
    tick();
    check("t1_done_t18", frame_done, 0);
    check("t1_busy_t18", busy, 0);
    repeat (3) tick();
    check("t1_word_count", rx_words.size(), N_CH);
    for (int i = 0; i < N_CH && i < rx_words.size(); i++)
      check($sformatf("t1_word%0d", i), rx_words[i], cell_word(1, i, i % 4, 3 - i % 4));

    // Mask / back-pressure scenarios.
    foreach (rows[r]) begin
      drain_and_clear();
      ch_mask   = rows[r].mask;
      out_ready = rows[r].ready;
      rx_count  = 0;
      phi1b_dig = 1'b1;
      tick();
      phi1b_dig = 1'b0;
      repeat (18) tick();
      check($sformatf("row%0d_drop_cnt", r), drop_cnt, rows[r].exp_drops);
      check($sformatf("row%0d_overflow", r), overflow, rows[r].exp_ovf);
      out_ready = 1'b1;
      repeat (10) tick();
      check($sformatf("row%0d_words", r), rx_count, rows[r].exp_words);
    end

    // Missed frame at slot 5, then a start exactly on the frame_done cycle.
    // Eight frames so far, so these two frames carry parity 1 then 0.
    drain_and_clear();
    ch_mask = '1;
    phi1b_dig = 1'b1;
    tick();
    phi1b_dig = 1'b0;
    tick();
    check("t4_data_t2", out_data, cell_word(1, 0, 0, 3));
    repeat (4) tick();
    phi1b_dig = 1'b1;
    tick();
    phi1b_dig = 1'b0;
    check("t4_missed", missed_frame, 1);
    check("t4_busy_after_miss", busy, 1);
    repeat (9) tick();
    check("t4_busy_t16", busy, 1);
    tick();
    check("t4_done_t17", frame_done, 1);
    phi1b_dig = 1'b1;
    tick();
    phi1b_dig = 1'b0;
    check("t4_busy_b2b", busy, 1);
    tick();
    check("t4_valid_new", out_valid, 1);
    check("t4_data_new", out_data, cell_word(0, 0, 0, 3));
    repeat (20) tick();

    // Abort by dropping en at slot 6 with the consumer stalled.
    drain_and_clear();
    out_ready = 1'b0;
    phi1b_dig = 1'b1;
    tick();
    phi1b_dig = 1'b0;
    repeat (6) tick();
    en = 1'b0;
    tick();
    check("t5_busy_after_abort", busy, 0);
    repeat (12) tick();
    check("t5_no_done", frame_done, 0);
    en = 1'b1;
    out_ready = 1'b1;
    rx_count = 0;
    repeat (10) tick();
    check("t5_words", rx_count, 6);

    // Clear in the same cycle as a drop: the drop wins.
    drain_and_clear();
    out_ready = 1'b0;
    phi1b_dig = 1'b1;
    tick();
    phi1b_dig = 1'b0;
    repeat (9) tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("setwins_drop_cnt", drop_cnt, 1);
    check("setwins_overflow", overflow, 1);

    // Full FIFO with a draining consumer, then an asynchronous reset mid-scan.
    drain_and_clear();
    out_ready = 1'b0;
    ch_mask = 16'h00FF;
    phi1b_dig = 1'b1;
    tick();
    phi1b_dig = 1'b0;
    repeat (18) tick();
    ch_mask = '1;
    out_ready = 1'b1;
    phi1b_dig = 1'b1;
    tick();
    phi1b_dig = 1'b0;
    repeat (8) tick();
    check("t6_no_drop", drop_cnt, 0);
    check("t6_no_overflow", overflow, 0);
    check("t6_valid", out_valid, 1);
    #2;
    rstb = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    tick();
    rstb = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      en             = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) phi1b_dig = ~phi1b_dig;
      ch_mask        = N_CH'($urandom);
      out_ready      = ($urandom_range(0, 3) != 0);
      clr_flags      = ($urandom_range(0, 29) == 0);
      read_out_I_bus = $urandom;
      read_out_Q_bus = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
